// File: rtl/lcd_rx_pkg.sv
// Shared types and helpers for the RGB LCD receive path.
package lcd_rx_pkg;

    localparam int XY_W_DEF = 11;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        SKIP,
        CAPTURE
    } state_t;

    // Truncate RGB888 to RGB565 by keeping the MSBs of each channel.
    function automatic logic [15:0] rgb888_to_565(input logic [23:0] rgb);
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
    endfunction

endpackage

// File: rtl/lcd_rx_sync_edge.sv
// Two-stage input register for the LCD pins with sync polarity normalised
// to active-high, plus VS entering-active and DE falling edge detection.
module lcd_rx_sync_edge #(
    parameter logic VS_POL = 1'b0,
    parameter logic HS_POL = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        vs_i,
    input  logic        hs_i,
    input  logic        de_i,
    input  logic [23:0] rgb_i,
    output logic        hs_act_o,
    output logic        de_o,
    output logic [23:0] rgb_o,
    output logic        vs_edge_o,
    output logic        de_fall_o
);

    logic        vs_d1_q;
    logic        vs_d2_q;
    logic        hs_d1_q;
    logic        de_d1_q;
    logic        de_d2_q;
    logic [23:0] rgb_d1_q;

    // d1 samples the pins (sync levels made active-high); d2 delays VS/DE for edge compare.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vs_d1_q  <= 1'b0;
            vs_d2_q  <= 1'b0;
            hs_d1_q  <= 1'b0;
            de_d1_q  <= 1'b0;
            de_d2_q  <= 1'b0;
            rgb_d1_q <= '0;
        end else begin
            vs_d1_q  <= (vs_i == VS_POL);
            hs_d1_q  <= (hs_i == HS_POL);
            de_d1_q  <= de_i;
            rgb_d1_q <= rgb_i;
            vs_d2_q  <= vs_d1_q;
            de_d2_q  <= de_d1_q;
        end
    end

    assign hs_act_o  = hs_d1_q;
    assign de_o      = de_d1_q;
    assign rgb_o     = rgb_d1_q;
    assign vs_edge_o = vs_d1_q & ~vs_d2_q;
    assign de_fall_o = de_d2_q & ~de_d1_q;

endmodule

// File: rtl/lcd_rgb_rx.sv
// Parallel RGB LCD receiver: frame-skip capture FSM, pixel coordinate
// counters, resolution measurement and RGB565 pixel write stream.
module lcd_rgb_rx
    import lcd_rx_pkg::*;
#(
    parameter int   FRAME_SKIP = 4,
    parameter logic VS_POL     = 1'b0,
    parameter logic HS_POL     = 1'b0,
    parameter int   XY_W       = XY_W_DEF
) (
    input  logic            lcd_pclk,
    input  logic            sys_rst,
    input  logic            capture_en,
    input  logic            lcd_vs,
    input  logic            lcd_hs,
    input  logic            lcd_de,
    input  logic [23:0]     lcd_rgb,
    output logic            pix_valid,
    output logic [15:0]     pix_data,
    output logic [XY_W-1:0] pixel_xpos,
    output logic [XY_W-1:0] pixel_ypos,
    output logic            frame_start,
    output logic            frame_done,
    output logic [XY_W-1:0] h_disp,
    output logic [XY_W-1:0] v_disp,
    output logic            res_valid,
    output logic            line_err
);

    localparam logic [XY_W-1:0] XY_MAX    = '1;
    localparam logic [7:0]      SKIP_LAST = (FRAME_SKIP > 0) ? 8'(FRAME_SKIP - 1) : 8'd0;

    logic        hs_act, de1, vs_edge, de_fall;
    logic [23:0] rgb1;

    state_t          state_q, state_d;
    logic [7:0]      skip_q, skip_d;
    logic [XY_W-1:0] x_q, x_d, y_q, y_d, ref_q, ref_d;
    logic [XY_W-1:0] cur_x, cur_y, lines_cls, ref_cls;
    logic            emit, line_end, err_set, frame_close;

    logic            pix_valid_q, fstart_q, fdone_q, res_q, err_q;
    logic [15:0]     pix_data_q;
    logic [XY_W-1:0] xpos_q, ypos_q, h_q, v_q;

    lcd_rx_sync_edge #(
        .VS_POL (VS_POL),
        .HS_POL (HS_POL)
    ) u_sync (
        .clk_i     (lcd_pclk),
        .rst_i     (sys_rst),
        .vs_i      (lcd_vs),
        .hs_i      (lcd_hs),
        .de_i      (lcd_de),
        .rgb_i     (lcd_rgb),
        .hs_act_o  (hs_act),
        .de_o      (de1),
        .rgb_o     (rgb1),
        .vs_edge_o (vs_edge),
        .de_fall_o (de_fall)
    );

    // Capture FSM state and skipped-frame counter.
    always_ff @(posedge lcd_pclk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            skip_q  <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    // Next-state: enable is honoured at once while waiting, but only at a VS edge once capturing.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        case (state_q)
            IDLE: begin
                if (capture_en) state_d = SYNC;
            end
            SYNC: begin
                if (!capture_en) begin
                    state_d = IDLE;
                end else if (vs_edge) begin
                    skip_d  = '0;
                    state_d = (FRAME_SKIP == 0) ? CAPTURE : SKIP;
                end
            end
            SKIP: begin
                if (!capture_en) begin
                    state_d = IDLE;
                end else if (vs_edge) begin
                    if (skip_q == SKIP_LAST) state_d = CAPTURE;
                    else                     skip_d  = skip_q + 8'd1;
                end
            end
            CAPTURE: begin
                if (vs_edge && !capture_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A pixel is emitted whenever the cycle ends in CAPTURE, so a pixel coinciding
    // with the opening VS edge is kept as (0,0) and one on a closing edge is dropped.
    assign emit     = de1 && (state_d == CAPTURE);
    assign line_end = de_fall && (state_q == CAPTURE) && (x_q != '0);

    // Coordinate counters, reference line length and error detection.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        ref_d     = ref_q;
        cur_x     = x_q;
        cur_y     = y_q;
        err_set   = 1'b0;
        if (line_end) begin
            if (y_q == '0)        ref_d   = x_q;
            else if (x_q != ref_q) err_set = 1'b1;
            if (y_q == XY_MAX)    err_set = 1'b1;
            else                  y_d     = y_q + 1'b1;
            x_d = '0;
        end
        // Values describing the frame that a VS edge on this cycle would close.
        lines_cls = y_d;
        ref_cls   = ref_d;
        if (vs_edge) begin
            x_d   = '0;
            y_d   = '0;
            cur_x = '0;
            cur_y = '0;
        end
        if (emit) begin
            if (cur_x == XY_MAX) err_set = 1'b1;
            else                 x_d     = cur_x + 1'b1;
            if (hs_act)          err_set = 1'b1;
        end
    end

    assign frame_close = vs_edge && (state_q == CAPTURE) && (lines_cls != '0);

    // Counters, pixel output stage, resolution measurement and sticky error.
    always_ff @(posedge lcd_pclk or posedge sys_rst) begin
        if (sys_rst) begin
            x_q         <= '0;
            y_q         <= '0;
            ref_q       <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            xpos_q      <= '0;
            ypos_q      <= '0;
            fstart_q    <= 1'b0;
            fdone_q     <= 1'b0;
            h_q         <= '0;
            v_q         <= '0;
            res_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            ref_q       <= ref_d;
            pix_valid_q <= emit;
            fstart_q    <= emit && (cur_x == '0) && (cur_y == '0);
            fdone_q     <= frame_close;
            if (emit) begin
                pix_data_q <= rgb888_to_565(rgb1);
                xpos_q     <= cur_x;
                ypos_q     <= cur_y;
            end
            if (frame_close) begin
                h_q   <= ref_cls;
                v_q   <= lines_cls;
                res_q <= 1'b1;
            end
            if (state_q == IDLE && state_d == SYNC) err_q <= 1'b0;
            else if (err_set)                       err_q <= 1'b1;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign pixel_xpos  = xpos_q;
    assign pixel_ypos  = ypos_q;
    assign frame_start = fstart_q;
    assign frame_done  = fdone_q;
    assign h_disp      = h_q;
    assign v_disp      = v_q;
    assign res_valid   = res_q;
    assign line_err    = err_q;

endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Self-checking bench for lcd_rgb_rx: scaled-down frames, random pixels,
// expected pixel stream built from frame geometry and RGB565 arithmetic.
module tb_lcd_rgb_rx;

    localparam int W = 16;
    localparam int H = 8;

    typedef struct packed {
        logic [15:0] d;
        logic [10:0] x;
        logic [10:0] y;
        logic        fs;
        logic [31:0] c;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en1 = 1'b0;
    logic        en2 = 1'b0;
    logic        va = 1'b0, ha = 1'b0, de = 1'b0;
    logic [23:0] rgb = '0;
    logic        vs_n, hs_n;

    logic        pv1, fs1, fd1, rv1, le1;
    logic [15:0] pd1;
    logic [10:0] px1, py1, hd1, vd1;
    logic        pv2, fs2, fd2, rv2, le2;
    logic [15:0] pd2;
    logic [3:0]  px2, py2, hd2, vd2;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int          fd_total = 0;
    int          fd2_total = 0;
    pix_t        mon_q[$];
    pix_t        exp_q[$];
    logic [3:0]  mon2_x[$];
    logic [3:0]  mon2_y[$];
    bit          expect_cap = 1'b0;
    bit          force_first = 1'b0;
    logic [23:0] first_px = '0;

    always #5 clk = ~clk;

    assign vs_n = ~va;
    assign hs_n = ~ha;

    lcd_rgb_rx #(.FRAME_SKIP(4), .VS_POL(1'b0), .HS_POL(1'b0), .XY_W(11)) dut1 (
        .lcd_pclk(clk), .sys_rst(rst), .capture_en(en1),
        .lcd_vs(vs_n), .lcd_hs(hs_n), .lcd_de(de), .lcd_rgb(rgb),
        .pix_valid(pv1), .pix_data(pd1), .pixel_xpos(px1), .pixel_ypos(py1),
        .frame_start(fs1), .frame_done(fd1), .h_disp(hd1), .v_disp(vd1),
        .res_valid(rv1), .line_err(le1)
    );

    lcd_rgb_rx #(.FRAME_SKIP(0), .VS_POL(1'b1), .HS_POL(1'b1), .XY_W(4)) dut2 (
        .lcd_pclk(clk), .sys_rst(rst), .capture_en(en2),
        .lcd_vs(va), .lcd_hs(ha), .lcd_de(de), .lcd_rgb(rgb),
        .pix_valid(pv2), .pix_data(pd2), .pixel_xpos(px2), .pixel_ypos(py2),
        .frame_start(fs2), .frame_done(fd2), .h_disp(hd2), .v_disp(vd2),
        .res_valid(rv2), .line_err(le2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        pix_t m;
        if (pv1 === 1'b1) begin
            m.d = pd1; m.x = px1; m.y = py1; m.fs = fs1; m.c = cyc;
            mon_q.push_back(m);
        end
        if (fd1 === 1'b1) fd_total++;
        if (pv2 === 1'b1) begin
            mon2_x.push_back(px2);
            mon2_y.push_back(py2);
        end
        if (fd2 === 1'b1) fd2_total++;
    end

    // One pixel clock of source signals (active-level view).
    task automatic drive(input logic v, input logic h, input logic d, input logic [23:0] p);
        @(posedge clk);
        #1;
        va = v; ha = h; de = d; rgb = p;
    endtask

    task automatic vs_pulse();
        drive(1'b0, 1'b0, 1'b0, '0);
        repeat (3) drive(1'b1, 1'b0, 1'b0, '0);
        repeat (3) drive(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic drive_line(input int y, input int len);
        logic [23:0] p;
        pix_t        e;
        int          r, g, b;
        repeat (2) drive(1'b0, 1'b1, 1'b0, '0);
        repeat (2) drive(1'b0, 1'b0, 1'b0, '0);
        for (int x = 0; x < len; x++) begin
            p = 24'($urandom);
            if (force_first && x == 0 && y == 0) p = first_px;
            drive(1'b0, 1'b0, 1'b1, p);
            if (expect_cap) begin
                r = int'(p[23:16]); g = int'(p[15:8]); b = int'(p[7:0]);
                e.d  = 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
                e.x  = 11'(x);
                e.y  = 11'(y);
                e.fs = (x == 0 && y == 0);
                e.c  = cyc + 2;
                exp_q.push_back(e);
            end
        end
        repeat (2) drive(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic drive_frame(input int w, input int h, input int short_y,
                               input int short_len, input int drop_y);
        vs_pulse();
        for (int y = 0; y < h; y++) begin
            if (y == drop_y) en1 = 1'b0;
            drive_line(y, (y == short_y) ? short_len : w);
        end
        repeat (2) drive(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (pv1 !== 1'b0) begin errors++; $display("FAIL reset_pix_valid: got %b want 0", pv1); end
        checks++;
        if ({pd1, px1, py1} !== '0) begin errors++; $display("FAIL reset_pixel: got %h/%0d/%0d want 0", pd1, px1, py1); end
        checks++;
        if ({fs1, fd1, rv1, le1} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {fs1, fd1, rv1, le1}); end
        checks++;
        if ({hd1, vd1} !== '0) begin errors++; $display("FAIL reset_res: got %0dx%0d want 0x0", hd1, vd1); end
        rst = 1'b0;
    endtask

    task automatic test_skip_capture();
        int base, fd0, bad;
        base = mon_q.size(); fd0 = fd_total;
        en1 = 1'b1; expect_cap = 1'b0;
        repeat (4) drive_frame(W, H, -1, 0, -1);
        checks++;
        if (mon_q.size() != base) begin errors++; $display("FAIL skip_no_pixels: got %0d pixels want 0", mon_q.size() - base); end
        checks++;
        if (fd_total != fd0) begin errors++; $display("FAIL skip_no_done: got %0d want 0", fd_total - fd0); end
        exp_q.delete(); expect_cap = 1'b1;
        drive_frame(W, H, -1, 0, -1);
        expect_cap = 1'b0;
        vs_pulse();
        checks++;
        if (mon_q.size() - base != exp_q.size()) begin errors++; $display("FAIL cap_count: got %0d want %0d", mon_q.size() - base, exp_q.size()); end
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i >= mon_q.size() || mon_q[base + i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL cap_pixels: got %0d wrong want 0", bad); end
        checks++;
        if (fd_total - fd0 != 1) begin errors++; $display("FAIL cap_frame_done: got %0d want 1", fd_total - fd0); end
        checks++;
        if (hd1 !== 11'(W) || vd1 !== 11'(H)) begin errors++; $display("FAIL cap_res: got %0dx%0d want %0dx%0d", hd1, vd1, W, H); end
        checks++;
        if (rv1 !== 1'b1 || le1 !== 1'b0) begin errors++; $display("FAIL cap_flags: got res_valid=%b line_err=%b want 1/0", rv1, le1); end
    endtask

    task automatic test_known_pixel();
        int base;
        base = mon_q.size();
        exp_q.delete(); expect_cap = 1'b1;
        force_first = 1'b1; first_px = 24'hFF8040;
        drive_frame(W, H, -1, 0, -1);
        expect_cap = 1'b0; force_first = 1'b0;
        vs_pulse();
        checks++;
        if (mon_q.size() <= base) begin
            errors++; $display("FAIL known_present: got 0 pixels want %0d", exp_q.size());
        end else begin
            if (mon_q[base].d !== 16'hFC08 || mon_q[base].fs !== 1'b1)
            begin errors++; $display("FAIL known_pixel: got %h fs=%b want fc08 fs=1", mon_q[base].d, mon_q[base].fs); end
            checks++;
            if (mon_q[base].c !== exp_q[0].c || mon_q[base].x !== 11'd0 || mon_q[base].y !== 11'd0)
            begin errors++; $display("FAIL known_latency: got cyc %0d (%0d,%0d) want cyc %0d (0,0)", mon_q[base].c, mon_q[base].x, mon_q[base].y, exp_q[0].c); end
        end
    endtask

    task automatic test_short_line();
        int base, fd0, bad;
        base = mon_q.size(); fd0 = fd_total;
        exp_q.delete(); expect_cap = 1'b1;
        drive_frame(10, 6, 3, 9, -1);
        expect_cap = 1'b0;
        vs_pulse();
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i >= mon_q.size() || mon_q[base + i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0 || mon_q.size() - base != exp_q.size()) begin errors++; $display("FAIL short_pixels: got %0d wrong of %0d want 0", bad, mon_q.size() - base); end
        checks++;
        if (le1 !== 1'b1) begin errors++; $display("FAIL short_line_err: got %b want 1", le1); end
        checks++;
        if (hd1 !== 11'd10 || vd1 !== 11'd6 || fd_total - fd0 != 1) begin errors++; $display("FAIL short_res: got %0dx%0d done=%0d want 10x6 done=1", hd1, vd1, fd_total - fd0); end
        drive_frame(10, 6, -1, 0, -1);
        vs_pulse();
        checks++;
        if (le1 !== 1'b1 || fd_total - fd0 != 2) begin errors++; $display("FAIL short_sticky: got line_err=%b done=%0d want 1/2", le1, fd_total - fd0); end
    endtask

    task automatic test_reset_midline();
        int base, fd0, bad, waited;
        expect_cap = 1'b0;
        fork
            drive_frame(W, H, -1, 0, -1);
            begin
                waited = 0;
                while (!(pv1 === 1'b1 && px1 == 11'd5) && waited < 400) begin
                    @(negedge clk);
                    waited++;
                end
                checks++;
                if (pv1 !== 1'b1) begin errors++; $display("FAIL rst_pre_active: got pix_valid=%b want 1", pv1); end
                #2 rst = 1'b1;
                #1;
                checks++;
                if ({pv1, fs1, fd1} !== 3'b0 || {pd1, px1, py1} !== '0) begin errors++; $display("FAIL rst_async_pixel: got pv=%b %h (%0d,%0d) want all 0", pv1, pd1, px1, py1); end
                checks++;
                if ({rv1, le1} !== 2'b0 || {hd1, vd1} !== '0) begin errors++; $display("FAIL rst_async_state: got rv=%b le=%b %0dx%0d want 0", rv1, le1, hd1, vd1); end
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        join
        base = mon_q.size(); fd0 = fd_total;
        repeat (4) drive_frame(W, H, -1, 0, -1);
        checks++;
        if (mon_q.size() != base || fd_total != fd0) begin errors++; $display("FAIL rst_skip: got %0d pixels %0d done want 0/0", mon_q.size() - base, fd_total - fd0); end
        exp_q.delete(); expect_cap = 1'b1;
        drive_frame(W, H, -1, 0, -1);
        expect_cap = 1'b0;
        vs_pulse();
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i >= mon_q.size() || mon_q[base + i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0 || mon_q.size() - base != W * H) begin errors++; $display("FAIL rst_recapture: got %0d pixels %0d wrong want %0d/0", mon_q.size() - base, bad, W * H); end
        checks++;
        if (fd_total - fd0 != 1 || le1 !== 1'b0) begin errors++; $display("FAIL rst_recap_done: got done=%0d le=%b want 1/0", fd_total - fd0, le1); end
    endtask

    task automatic test_en_drop();
        int base, fd0, bad;
        base = mon_q.size(); fd0 = fd_total;
        exp_q.delete(); expect_cap = 1'b1;
        drive_frame(W, H, -1, 0, 4);
        expect_cap = 1'b0;
        vs_pulse();
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i >= mon_q.size() || mon_q[base + i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0 || mon_q.size() - base != W * H) begin errors++; $display("FAIL drop_pixels: got %0d pixels %0d wrong want %0d/0", mon_q.size() - base, bad, W * H); end
        checks++;
        if (fd_total - fd0 != 1) begin errors++; $display("FAIL drop_done: got %0d want 1", fd_total - fd0); end
        base = mon_q.size();
        drive_frame(W, H, -1, 0, -1);
        vs_pulse();
        checks++;
        if (mon_q.size() != base || fd_total - fd0 != 1) begin errors++; $display("FAIL drop_idle: got %0d pixels done=%0d want 0/1", mon_q.size() - base, fd_total - fd0); end
    endtask

    task automatic test_saturation();
        int base, fd0, bad, k;
        base = mon2_x.size(); fd0 = fd2_total;
        en2 = 1'b1; expect_cap = 1'b0;
        drive_frame(20, 3, -1, 0, -1);
        en2 = 1'b0;
        vs_pulse();
        checks++;
        if (mon2_x.size() - base != 60) begin errors++; $display("FAIL sat_count: got %0d want 60", mon2_x.size() - base); end
        bad = 0; k = base;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 20; x++) begin
                if (k >= mon2_x.size() || mon2_x[k] !== 4'((x > 15) ? 15 : x) || mon2_y[k] !== 4'(y)) bad++;
                k++;
            end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL sat_coords: got %0d wrong want 0", bad); end
        checks++;
        if (le2 !== 1'b1 || rv2 !== 1'b1) begin errors++; $display("FAIL sat_flags: got le=%b rv=%b want 1/1", le2, rv2); end
        checks++;
        if (vd2 !== 4'd3 || fd2_total - fd0 != 1) begin errors++; $display("FAIL sat_frame: got v=%0d done=%0d want 3/1", vd2, fd2_total - fd0); end
    endtask

    initial begin
        test_reset();
        test_skip_capture();
        test_known_pixel();
        test_short_line();
        test_reset_midline();
        test_en_drop();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
